// File: rtl/circle_buf_reader_pkg.sv
// circle_buf_reader_pkg
//   Shared definitions for the circular-buffer readout sequencer:
//   FSM state encoding, header bit positions and FIFO entry field offsets.
//   FIFO entry layout is {first, last, data[dw-1:0]}.

package circle_buf_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_READ   = 3'd2,
        ST_REWIND = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    // Replay marker sits in the MSB of the header word.
    function automatic int hdr_replay_bit(input int dw);
        return dw - 1;
    endfunction

    // FIFO entry flag positions, just above the data field.
    function automatic int fe_last_bit(input int dw);
        return dw;
    endfunction

    function automatic int fe_first_bit(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/circle_buf_reader_fifo.sv
// circle_buf_reader_fifo
//   Small synchronous FIFO with registered storage and an occupancy count.
//   Ports:
//     clk, reset_n      clock, async active-low reset (pointers/count cleared)
//     i_push/i_push_data write request; ignored when full
//     i_pop             read request; ignored when empty
//     o_data            head entry (valid when o_valid)
//     o_valid           FIFO non-empty
//     o_count           occupancy, 0 .. 2^AW
//     o_full            occupancy == 2^AW

module circle_buf_reader_fifo #(
    parameter int WIDTH = 18,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [AW:0]      o_count,
    output logic             o_full
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_valid   = (r_count != '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & o_valid;

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wptr] <= i_push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/circle_buf_reader.sv
// circle_buf_reader
//   Readout sequencer for the read side of a double-banked circular capture
//   buffer. Waits for a full bank, emits a header word, strobes the bank out
//   word by word and streams everything through a small output FIFO.
//   Supports replay (rewind and re-read the current bank).
//   Ports:
//     clk, reset_n          clock (buffer rclk), async active-low reset
//     enable                start readout (sampled in IDLE)
//     replay                one-cycle request to re-read the current bank
//     r_bank_available      buffer holds a complete bank
//     r_addr                buffer read address (sanity check at header)
//     data_r/data_gate_out  buffer read data, valid one cycle after stb_r
//     stb_r, rewind         buffer read strobe / read-address reset pulse
//     m_data/m_valid/m_ready/m_first/m_last   output stream
//     frame_count           completed frames, wraps at 2^16
//     sync_err              sticky error flag

module circle_buf_reader
    import circle_buf_reader_pkg::*;
#(
    parameter int aw      = 13,
    parameter int dw      = 16,
    parameter int fifo_aw = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          replay,
    input  logic          r_bank_available,
    input  logic [aw-1:0] r_addr,
    input  logic [dw-1:0] data_r,
    input  logic          data_gate_out,
    output logic          stb_r,
    output logic          rewind,
    output logic [dw-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_first,
    output logic          m_last,
    output logic [15:0]   frame_count,
    output logic          sync_err
);

    localparam int          DEPTH      = 1 << fifo_aw;
    localparam int          CW         = fifo_aw + 2;
    localparam int          FE_W       = dw + 2;
    localparam int          FE_LAST    = fe_last_bit(dw);
    localparam int          FE_FIRST   = fe_first_bit(dw);
    localparam int          REPLAY_BIT = hdr_replay_bit(dw);
    localparam logic [aw:0] LAST_IDX   = {1'b0, {aw{1'b1}}};

    state_t           r_state;
    state_t           w_next;
    logic [aw:0]      r_rcnt;
    logic             r_inflight;
    logic             r_replay_pend;
    logic             r_replay_flag;
    logic [15:0]      r_frame_count;
    logic             r_sync_err;

    logic [fifo_aw:0] w_fifo_count;
    logic             w_fifo_full;
    logic             w_fifo_valid;
    logic [FE_W-1:0]  w_fifo_head;
    logic             w_push;
    logic [FE_W-1:0]  w_push_data;
    logic             w_pop;
    logic             w_credit_ok;
    logic             w_hdr_push;
    logic             w_last_stb;
    logic             w_frame_done;
    logic             w_abort;
    logic [dw-1:0]    w_hdr;

    // Count the word already requested from the buffer as occupied, so a
    // returning word always finds a free slot.
    assign w_credit_ok = ({1'b0, w_fifo_count} + CW'(r_inflight)) < CW'(DEPTH);

    always_comb begin
        w_hdr             = '0;
        w_hdr[dw-2:0]     = (dw-1)'(r_frame_count);
        w_hdr[REPLAY_BIT] = r_replay_flag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        stb_r      = 1'b0;
        rewind     = 1'b0;
        w_hdr_push = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && r_bank_available)
                    w_next = ST_HDR;
            end
            ST_HDR: begin
                // A returning data word owns the push port; defer the header.
                if (!w_fifo_full && !data_gate_out) begin
                    w_hdr_push = 1'b1;
                    w_next     = ST_READ;
                end
            end
            ST_READ: begin
                if (!r_bank_available) begin
                    w_next = ST_IDLE;
                end else if (r_replay_pend) begin
                    if (!r_inflight)
                        w_next = ST_REWIND;
                end else if (w_credit_ok) begin
                    stb_r = 1'b1;
                    if (r_rcnt == LAST_IDX)
                        w_next = ST_DRAIN;
                end
            end
            ST_REWIND: begin
                rewind = 1'b1;
                w_next = ST_HDR;
            end
            ST_DRAIN: begin
                if (!r_inflight)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_last_stb   = stb_r & (r_rcnt == LAST_IDX);
    assign w_frame_done = (r_state == ST_DRAIN) & ~r_inflight;
    assign w_abort      = (r_state == ST_READ) & ~r_bank_available;

    // Returning buffer words take priority; the word that lands in DRAIN is
    // the one fetched by the final strobe, so it carries the last flag.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        if (data_gate_out) begin
            w_push      = ~w_fifo_full;
            w_push_data = {1'b0, (r_state == ST_DRAIN), data_r};
        end else if (w_hdr_push) begin
            w_push      = 1'b1;
            w_push_data = {1'b1, 1'b0, w_hdr};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rcnt        <= '0;
            r_inflight    <= 1'b0;
            r_replay_pend <= 1'b0;
            r_replay_flag <= 1'b0;
            r_frame_count <= '0;
            r_sync_err    <= 1'b0;
        end else begin
            r_inflight <= stb_r;

            if (w_hdr_push)
                r_rcnt <= '0;
            else if (stb_r)
                r_rcnt <= r_rcnt + (aw+1)'(1);

            // The final strobe hands the bank back, so a replay arriving
            // with it has nothing left to re-read.
            if (r_state != ST_READ)
                r_replay_pend <= 1'b0;
            else if (replay && !w_last_stb && r_bank_available)
                r_replay_pend <= 1'b1;

            if (r_state == ST_REWIND)
                r_replay_flag <= 1'b1;
            else if (w_frame_done || w_abort)
                r_replay_flag <= 1'b0;

            if (w_frame_done)
                r_frame_count <= r_frame_count + 16'd1;

            if ((data_gate_out && w_fifo_full) ||
                (w_hdr_push && (r_addr != '0)) ||
                w_abort)
                r_sync_err <= 1'b1;
        end
    end

    circle_buf_reader_fifo #(
        .WIDTH (FE_W),
        .AW    (fifo_aw)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_data      (w_fifo_head),
        .o_valid     (w_fifo_valid),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full)
    );

    assign w_pop       = w_fifo_valid & m_ready;
    assign m_valid     = w_fifo_valid;
    assign m_data      = w_fifo_head[dw-1:0];
    assign m_first     = w_fifo_valid & w_fifo_head[FE_FIRST];
    assign m_last      = w_fifo_valid & w_fifo_head[FE_LAST];
    assign frame_count = r_frame_count;
    assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_circle_buf_reader.sv
// Testbench for circle_buf_reader (aw=3, dw=16, fifo_aw=2) with a buffer
// model returning 0xA000 + address one cycle after each strobe.

module tb_circle_buf_reader;

    localparam int AW  = 3;
    localparam int DW  = 16;
    localparam int FAW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          enable = 1'b0;
    logic          replay = 1'b0;
    logic          r_bank_available = 1'b0;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] data_r;
    logic          data_gate_out;
    logic          stb_r;
    logic          rewind;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_first;
    logic          m_last;
    logic [15:0]   frame_count;
    logic          sync_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    circle_buf_reader #(.aw(AW), .dw(DW), .fifo_aw(FAW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .replay           (replay),
        .r_bank_available (r_bank_available),
        .r_addr           (r_addr),
        .data_r           (data_r),
        .data_gate_out    (data_gate_out),
        .stb_r            (stb_r),
        .rewind           (rewind),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_first          (m_first),
        .m_last           (m_last),
        .frame_count      (frame_count),
        .sync_err         (sync_err)
    );

    // Buffer read-side model: address advances per strobe, rewinds on the
    // rewind pulse and restarts when the bank disappears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr        <= '0;
            data_r        <= '0;
            data_gate_out <= 1'b0;
        end else begin
            data_gate_out <= stb_r;
            if (stb_r)
                data_r <= 16'hA000 + 16'(r_addr);
            if (rewind || !r_bank_available)
                r_addr <= '0;
            else if (stb_r)
                r_addr <= r_addr + 3'd1;
        end
    end

    // Stream / strobe monitor
    logic [17:0] beat_mem [0:255];
    int          beat_n = 0;
    int          stb_n = 0;
    int          rew_n = 0;
    int          valid_n = 0;
    int          rew_bad = 0;
    logic        prev_stb = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (m_valid && m_ready) begin
                beat_mem[beat_n[7:0]] <= {m_first, m_last, m_data};
                beat_n <= beat_n + 1;
            end
            if (stb_r)   stb_n   <= stb_n + 1;
            if (rewind)  rew_n   <= rew_n + 1;
            if (m_valid) valid_n <= valid_n + 1;
            if (rewind && (stb_r || prev_stb)) rew_bad <= rew_bad + 1;
            prev_stb <= stb_r;
        end else begin
            prev_stb <= 1'b0;
        end
    end

    task automatic do_reset;
        reset_n = 1'b0;
        enable = 1'b0;
        replay = 1'b0;
        m_ready = 1'b1;
        r_bank_available = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic start_frame;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic wait_frames(input int exp);
        int n;
        n = 0;
        while (frame_count !== 16'(exp) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3 reset_n = 1'b0;
        r_bank_available = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({stb_r, rewind, m_valid, m_first, m_last, sync_err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {stb_r, rewind, m_valid, m_first, m_last, sync_err});
        end
        vectors++;
        if (frame_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_frame_count: got %h expected 0000", frame_count);
        end
    endtask

    task automatic test_full_frame;
        int b, s;
        logic [17:0] e;
        do_reset();
        b = beat_n; s = stb_n;
        start_frame();
        wait_frames(1);
        vectors++;
        if (beat_n - b !== 9) begin
            miscompares++;
            $display("FAIL full_beats: got %0d expected 9", beat_n - b);
        end
        for (int i = 0; i < 9; i++) begin
            e = (i == 0) ? {2'b10, 16'h0000} : {1'b0, (i == 8), 16'hA000 + 16'(i - 1)};
            vectors++;
            if (beat_mem[b + i] !== e) begin
                miscompares++;
                $display("FAIL full_beat%0d: got %h expected %h", i, beat_mem[b + i], e);
            end
        end
        vectors++;
        if (stb_n - s !== 8) begin
            miscompares++;
            $display("FAIL full_strobes: got %0d expected 8", stb_n - s);
        end
        vectors++;
        if (frame_count !== 16'd1 || sync_err !== 1'b0) begin
            miscompares++;
            $display("FAIL full_status: got fc=%h err=%b expected fc=0001 err=0",
                     frame_count, sync_err);
        end
    endtask

    task automatic test_backpressure;
        int b, s;
        logic [17:0] e;
        do_reset();
        m_ready = 1'b0;
        b = beat_n; s = stb_n;
        start_frame();
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (stb_n - s !== 3) begin
            miscompares++;
            $display("FAIL bp_strobes: got %0d expected 3", stb_n - s);
        end
        vectors++;
        if ({m_valid, m_first, m_data} !== {2'b11, 16'h0000}) begin
            miscompares++;
            $display("FAIL bp_head: got %b%b %h expected 11 0000", m_valid, m_first, m_data);
        end
        m_ready = 1'b1;
        wait_frames(1);
        vectors++;
        if (beat_n - b !== 9) begin
            miscompares++;
            $display("FAIL bp_beats: got %0d expected 9", beat_n - b);
        end
        for (int i = 0; i < 9; i++) begin
            e = (i == 0) ? {2'b10, 16'h0000} : {1'b0, (i == 8), 16'hA000 + 16'(i - 1)};
            vectors++;
            if (beat_mem[b + i] !== e) begin
                miscompares++;
                $display("FAIL bp_beat%0d: got %h expected %h", i, beat_mem[b + i], e);
            end
        end
        vectors++;
        if (stb_n - s !== 8 || sync_err !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_status: got stb=%0d err=%b expected stb=8 err=0",
                     stb_n - s, sync_err);
        end
    endtask

    task automatic test_replay;
        int b, r, n, k;
        logic [17:0] e;
        do_reset();
        b = beat_n; r = rew_n;
        start_frame();
        n = 0;
        while (beat_n - b < 4 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        replay = 1'b1;
        @(posedge clk); #1;
        replay = 1'b0;
        wait_frames(1);
        k = 0;
        for (int i = 1; i < beat_n - b; i++)
            if (k == 0 && beat_mem[b + i][17]) k = i;
        vectors++;
        if (k < 4) begin
            miscompares++;
            $display("FAIL rp_second_header_index: got %0d expected >=4", k);
        end
        vectors++;
        if (beat_mem[b] !== {2'b10, 16'h0000}) begin
            miscompares++;
            $display("FAIL rp_header0: got %h expected 20000", beat_mem[b]);
        end
        for (int i = 1; i < k; i++) begin
            e = {2'b00, 16'hA000 + 16'(i - 1)};
            vectors++;
            if (beat_mem[b + i] !== e) begin
                miscompares++;
                $display("FAIL rp_partial%0d: got %h expected %h", i, beat_mem[b + i], e);
            end
        end
        vectors++;
        if (beat_mem[b + k] !== {2'b10, 16'h8000}) begin
            miscompares++;
            $display("FAIL rp_header1: got %h expected 28000", beat_mem[b + k]);
        end
        for (int j = 0; j < 8; j++) begin
            e = {1'b0, (j == 7), 16'hA000 + 16'(j)};
            vectors++;
            if (beat_mem[b + k + 1 + j] !== e) begin
                miscompares++;
                $display("FAIL rp_data%0d: got %h expected %h", j, beat_mem[b + k + 1 + j], e);
            end
        end
        vectors++;
        if (beat_n - b !== k + 9) begin
            miscompares++;
            $display("FAIL rp_beats: got %0d expected %0d", beat_n - b, k + 9);
        end
        vectors++;
        if (rew_n - r !== 1 || rew_bad !== 0) begin
            miscompares++;
            $display("FAIL rp_rewind: got pulses=%0d overlap=%0d expected 1 0",
                     rew_n - r, rew_bad);
        end
        vectors++;
        if (frame_count !== 16'd1 || sync_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rp_status: got fc=%h err=%b expected fc=0001 err=0",
                     frame_count, sync_err);
        end
    endtask

    task automatic test_enable_gate;
        int s, v;
        do_reset();
        s = stb_n; v = valid_n;
        repeat (50) @(posedge clk);
        #1;
        vectors++;
        if (stb_n - s !== 0 || valid_n - v !== 0) begin
            miscompares++;
            $display("FAIL en_idle: got stb=%0d valid=%0d expected 0 0", stb_n - s, valid_n - v);
        end
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({m_valid, m_first, m_data} !== {2'b11, 16'h0000}) begin
            miscompares++;
            $display("FAIL en_start: got %b%b %h expected 11 0000", m_valid, m_first, m_data);
        end
        wait_frames(1);
        vectors++;
        if (frame_count !== 16'd1) begin
            miscompares++;
            $display("FAIL en_frame_count: got %h expected 0001", frame_count);
        end
    endtask

    task automatic test_async_reset;
        int s, n, b;
        logic [17:0] e;
        do_reset();
        s = stb_n;
        start_frame();
        n = 0;
        while (stb_n - s < 4 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        reset_n = 1'b0;
        #2;
        vectors++;
        if ({stb_r, rewind, m_valid, m_first, m_last, sync_err} !== 6'b0) begin
            miscompares++;
            $display("FAIL ar_outputs: got %b expected 000000",
                     {stb_r, rewind, m_valid, m_first, m_last, sync_err});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (frame_count !== 16'd0) begin
            miscompares++;
            $display("FAIL ar_frame_count: got %h expected 0000", frame_count);
        end
        b = beat_n;
        start_frame();
        wait_frames(1);
        vectors++;
        if (beat_n - b !== 9) begin
            miscompares++;
            $display("FAIL ar_beats: got %0d expected 9", beat_n - b);
        end
        for (int i = 0; i < 9; i++) begin
            e = (i == 0) ? {2'b10, 16'h0000} : {1'b0, (i == 8), 16'hA000 + 16'(i - 1)};
            vectors++;
            if (beat_mem[b + i] !== e) begin
                miscompares++;
                $display("FAIL ar_beat%0d: got %h expected %h", i, beat_mem[b + i], e);
            end
        end
    endtask

    task automatic test_bank_loss;
        int b, s, n, lasts;
        logic [17:0] e;
        do_reset();
        b = beat_n; s = stb_n;
        start_frame();
        n = 0;
        while (stb_n - s < 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        r_bank_available = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (sync_err !== 1'b1) begin
            miscompares++;
            $display("FAIL bl_sync_err: got %b expected 1", sync_err);
        end
        lasts = 0;
        for (int i = b; i < beat_n; i++)
            if (beat_mem[i][16]) lasts++;
        vectors++;
        if (lasts !== 0 || frame_count !== 16'd0) begin
            miscompares++;
            $display("FAIL bl_no_last: got lasts=%0d fc=%h expected 0 0000", lasts, frame_count);
        end
        s = stb_n;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (stb_n - s !== 0) begin
            miscompares++;
            $display("FAIL bl_idle: got %0d strobes expected 0", stb_n - s);
        end
        r_bank_available = 1'b1;
        @(posedge clk); #1;
        b = beat_n;
        start_frame();
        wait_frames(1);
        vectors++;
        if (beat_n - b !== 9 || frame_count !== 16'd1) begin
            miscompares++;
            $display("FAIL bl_second: got beats=%0d fc=%h expected 9 0001", beat_n - b, frame_count);
        end
        for (int i = 0; i < 9; i++) begin
            e = (i == 0) ? {2'b10, 16'h0000} : {1'b0, (i == 8), 16'hA000 + 16'(i - 1)};
            vectors++;
            if (beat_mem[b + i] !== e) begin
                miscompares++;
                $display("FAIL bl_beat%0d: got %h expected %h", i, beat_mem[b + i], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_replay();
        test_enable_gate();
        test_async_reset();
        test_bank_loss();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
